controlador_botoes: RTL

Input front-end for the four user buttons: synchronises and debounces the raw levels, turns each debounced press into a single event, and arbitrates simultaneous presses. Each accepted press is queued as a 2-bit button code in a small FIFO and handed to the consuming FSM through a valid/ready handshake. It sits between the board pins and the game/control logic, replacing ad-hoc level-to-pulse plus combinational encoding with a lossless, ordered event stream.

---
 rtl/controlador_botoes_pkg.sv | 32 +++
 rtl/controlador_botoes_debounce_botao.sv | 111 +++++++++++
 rtl/controlador_botoes.sv | 101 ++++++++++
 3 files changed

// File: rtl/controlador_botoes_pkg.sv
// Shared definitions for the button front-end.
// - Button codes as presented on S (B3 highest priority, encoded 00).
// - Debouncer state enumeration.
// - prio_code: fixed-priority encoder from a pending vector to a button code.
package controlador_botoes_pkg;

    localparam logic [1:0] COD_B3 = 2'b00;
    localparam logic [1:0] COD_B2 = 2'b01;
    localparam logic [1:0] COD_B1 = 2'b10;
    localparam logic [1:0] COD_B0 = 2'b11;

    typedef enum logic [1:0] {
        STABLE_LO,
        CHECK_HI,
        STABLE_HI,
        CHECK_LO
    } deb_state_t;

    // Highest set bit wins; B3 > B2 > B1 > B0. Result is don't-care when p == 0.
    function automatic logic [1:0] prio_code(input logic [3:0] p);
        if (p[3]) begin
            return COD_B3;
        end else if (p[2]) begin
            return COD_B2;
        end else if (p[1]) begin
            return COD_B1;
        end else begin
            return COD_B0;
        end
    endfunction

endpackage

// File: rtl/controlador_botoes_debounce_botao.sv
// debounce_botao: one button channel.
// Raw asynchronous level -> 2-FF synchroniser -> debounce FSM -> one-cycle press pulse.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   raw    raw button level (asynchronous)
//   press  registered one-cycle pulse when the debounced level goes high
module debounce_botao
    import controlador_botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;

    // State register (also holds synchroniser, counter and press pulse)
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            state <= state_next;
            cnt   <= cnt_next;
            press <= press_next;
        end
    end

    // Next-state logic. The first differing sample already counts as 1, so
    // with DEBOUNCE_CYCLES == 1 a STABLE state flips directly.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            STABLE_LO: begin
                if (sync2) begin
                    if (CNT_ONE == CNT_MAX) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHECK_HI;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            CHECK_HI: begin
                if (sync2) begin
                    if (cnt + CNT_ONE == CNT_MAX) begin
                        state_next = STABLE_HI;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    state_next = STABLE_LO;
                    cnt_next   = '0;
                end
            end
            STABLE_HI: begin
                if (!sync2) begin
                    if (CNT_ONE == CNT_MAX) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                    end else begin
                        state_next = CHECK_LO;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            CHECK_LO: begin
                if (!sync2) begin
                    if (cnt + CNT_ONE == CNT_MAX) begin
                        state_next = STABLE_LO;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    state_next = STABLE_HI;
                    cnt_next   = '0;
                end
            end
        endcase
    end

    // Press only on entry to STABLE_HI from the low side; CHECK_LO -> STABLE_HI
    // is an aborted release and must not produce an event.
    always_comb begin
        press_next = (state_next == STABLE_HI) && ((state == STABLE_LO) || (state == CHECK_HI));
    end

endmodule

// File: rtl/controlador_botoes.sv
// controlador_botoes: four-button input front-end.
// Debounces each button, converts presses to events, arbitrates them with fixed
// priority into a FIFO of 2-bit codes, and presents the head via valid/ready.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high
//   B[3:0]    raw button levels (active-high, asynchronous)
//   S[1:0]    code at FIFO head (00 when empty)
//   valid     S holds a queued press
//   ready     consumer accepts S when valid & ready
//   overflow  sticky: a press event was dropped
//   pending   per-button press waiting for a FIFO slot
module controlador_botoes
    import controlador_botoes_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] B,
    output logic [1:0] S,
    output logic       valid,
    input  logic       ready,
    output logic       overflow,
    output logic [3:0] pending
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [3:0]       press;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             can_accept;
    logic [1:0]       grant_code;
    logic [3:0]       grant;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        debounce_botao #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw  (B[i]),
            .press(press[i])
        );
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    always_comb begin
        pop        = (count != '0) && ready;
        can_accept = (count != CNT_W'(FIFO_DEPTH)) || pop;
        push       = (pending != 4'b0000) && can_accept;
        grant_code = prio_code(pending);
        // Code 00 maps to bit 3, code 11 to bit 0.
        grant      = push ? (4'b0001 << (2'd3 - grant_code)) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 4'b0000;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            // A bit granted this cycle may be re-armed by a simultaneous press.
            pending <= (pending & ~grant) | press;
            if ((press & pending & ~grant) != 4'b0000) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= grant_code;
        end
    end

    assign valid = (count != '0);
    assign S     = valid ? mem[rd_ptr] : COD_B3;

endmodule
